// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// 32-step radix-2 shift-add multiply or restoring divide on operand
// magnitudes, a single sign-fix cycle, and optional single-cycle early-out
// for divide-by-zero and signed overflow.
module rv32m_muldiv_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        KILL,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] OPA,
  input  logic [31:0] OPB,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        neg_q, neg_d;
  // Multiply: [64:32] partial product, [31:0] multiplier being shifted out.
  // Divide:   [64:32] partial remainder, [31:0] dividend/quotient.
  logic [64:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] opr_q, opr_d;
  logic [31:0] result_q, result_d;

  logic        is_div_in, signed_a, signed_b, sa, sb, b_zero, ovf, early;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [64:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Next-state, datapath step and result selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    result_d = result_q;

    is_div_in = FUNCT3[2];
    // MUL, MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU not rs2.
    signed_a  = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    signed_b  = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) ||
                (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    sa        = signed_a & OPA[31];
    sb        = signed_b & OPB[31];
    abs_a     = sa ? neg32(OPA) : OPA;
    abs_b     = sb ? neg32(OPB) : OPB;
    b_zero    = (OPB == 32'd0);
    ovf       = is_div_in && !FUNCT3[0] && (OPA == 32'h8000_0000) && (OPB == 32'hFFFF_FFFF);
    early     = EARLY_OUT && is_div_in && (b_zero || ovf);

    mul_sum   = acc_q[64:32] + {1'b0, opr_q};
    div_shift = {acc_q[63:0], 1'b0};
    div_diff  = {1'b0, div_shift[64:32]} - {2'b00, opr_q};

    prod_fix  = neg_q ? neg64(acc_q[63:0]) : acc_q[63:0];
    q_fix     = neg_q ? neg32(acc_q[31:0]) : acc_q[31:0];
    r_fix     = neg_q ? neg32(acc_q[63:32]) : acc_q[63:32];

    case (state_q)
      S_IDLE: begin
        if (START && !KILL) begin
          funct3_d = FUNCT3;
          cnt_d    = 5'd0;
          if (is_div_in) begin
            acc_d = {33'd0, abs_a};
            opr_d = abs_b;
            // A zero divisor leaves an all-ones quotient that must stay
            // unnegated; the remainder always follows the dividend sign.
            neg_d = FUNCT3[1] ? sa : ((sa ^ sb) & !b_zero);
          end else begin
            acc_d = {33'd0, abs_b};
            opr_d = abs_a;
            neg_d = sa ^ sb;
          end
          if (early) begin
            if (b_zero) result_d = FUNCT3[1] ? OPA : 32'hFFFF_FFFF;
            else        result_d = FUNCT3[1] ? 32'd0 : 32'h8000_0000;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (KILL) begin
          state_d = S_IDLE;
        end else begin
          if (funct3_q[2]) begin
            if (!div_diff[33]) acc_d = {div_diff[32:0], div_shift[31:1], 1'b1};
            else               acc_d = div_shift;
          end else begin
            if (acc_q[0]) acc_d = {mul_sum, acc_q[31:0]} >> 1;
            else          acc_d = acc_q >> 1;
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (KILL) begin
          state_d = S_IDLE;
        end else begin
          case (funct3_q)
            3'b000:                 result_d = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[63:32];
            3'b100, 3'b101:         result_d = q_fix;
            default:                result_d = r_fix;
          endcase
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      funct3_q <= 3'd0;
      neg_q    <= 1'b0;
      acc_q    <= 65'd0;
      opr_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q == S_CALC) || (state_q == S_FIX);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Testbench for rv32m_muldiv_unit: table of directed operations on an
// early-out instance and an iterative instance, plus kill, reset and
// held-start sequences.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_eo, start_it, kill;
  logic [2:0]  funct3;
  logic [31:0] opa, opb;
  logic        busy_eo, done_eo, busy_it, done_it;
  logic [31:0] result_eo, result_it;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rv32m_muldiv_unit #(.EARLY_OUT(1'b1)) dut_eo (
    .CLK(clk), .RESET(rst_n), .START(start_eo), .KILL(kill), .FUNCT3(funct3),
    .OPA(opa), .OPB(opb), .BUSY(busy_eo), .DONE(done_eo), .RESULT(result_eo));

  rv32m_muldiv_unit #(.EARLY_OUT(1'b0)) dut_it (
    .CLK(clk), .RESET(rst_n), .START(start_it), .KILL(kill), .FUNCT3(funct3),
    .OPA(opa), .OPB(opb), .BUSY(busy_it), .DONE(done_it), .RESULT(result_it));

  typedef struct {
    bit          eo;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Entered just after a falling edge; returns at the falling edge of the DONE cycle.
  task automatic run_op(input bit eo, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output int busy_bad);
    logic d, bz;
    funct3 = f; opa = a; opb = b;
    if (eo) start_eo = 1'b1; else start_it = 1'b1;
    @(negedge clk);
    start_eo = 1'b0; start_it = 1'b0;
    lat = 0; busy_bad = 0; res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 60; c++) begin
      d  = eo ? done_eo : done_it;
      bz = eo ? busy_eo : busy_it;
      if (d) begin
        lat = c;
        res = eo ? result_eo : result_it;
        if (bz) busy_bad++;
        break;
      end
      if (!bz) busy_bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, prior;
    int l, bb, pulses;

    vecs[0]  = '{1'b0, 3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[2]  = '{1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[3]  = '{1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[4]  = '{1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{1'b0, 3'b101, 32'd100,       32'd7,         32'd14,        34};
    vecs[7]  = '{1'b0, 3'b111, 32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{1'b1, 3'b100, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{1'b1, 3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 1};
    vecs[10] = '{1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{1'b1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{1'b0, 3'b100, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 34};
    vecs[13] = '{1'b0, 3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 34};
    vecs[14] = '{1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[15] = '{1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[16] = '{1'b0, 3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 34};
    vecs[17] = '{1'b0, 3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 34};
    vecs[18] = '{1'b1, 3'b001, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[19] = '{1'b1, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[20] = '{1'b0, 3'b000, 32'h0001_2345, 32'h0000_1000, 32'h1234_5000, 34};
    vecs[21] = '{1'b0, 3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, 34};

    rst_n = 1'b0; start_eo = 1'b0; start_it = 1'b0; kill = 1'b0;
    funct3 = 3'd0; opa = 32'd0; opb = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {30'd0, busy_eo, busy_it}, 32'd0);
    check("reset_done", {30'd0, done_eo, done_it}, 32'd0);
    check("reset_result_eo", result_eo, 32'd0);
    check("reset_result_it", result_it, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].eo, vecs[i].f, vecs[i].a, vecs[i].b, r, l, bb);
      check($sformatf("v%0d_result", i), r, vecs[i].exp);
      check($sformatf("v%0d_latency", i), l, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bb, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_width", i),
            {31'd0, vecs[i].eo ? done_eo : done_it}, 32'd0);
    end

    // KILL together with START in IDLE drops the request
    funct3 = 3'b000; opa = 32'd3; opb = 32'd3; start_it = 1'b1; kill = 1'b1;
    @(negedge clk);
    start_it = 1'b0; kill = 1'b0;
    check("kill_start_idle_busy", {31'd0, busy_it}, 32'd0);
    @(negedge clk);
    check("kill_start_idle_done", {31'd0, done_it}, 32'd0);

    // KILL at cycle 10 of a DIV
    prior = result_it;
    funct3 = 3'b100; opa = 32'd100; opb = 32'd7; start_it = 1'b1;
    @(negedge clk);
    start_it = 1'b0;
    repeat (9) @(negedge clk);
    check("kill_busy_before", {31'd0, busy_it}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_after", {31'd0, busy_it}, 32'd0);
    check("kill_result_kept", result_it, prior);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_it) pulses++;
      @(negedge clk);
    end
    check("kill_no_done", pulses, 32'd0);
    run_op(1'b0, 3'b000, 32'd5, 32'd6, r, l, bb);
    check("after_kill_mul", r, 32'd30);
    check("after_kill_lat", l, 32'd34);
    @(negedge clk);

    // RESET low at cycle 20 of a MULHU
    funct3 = 3'b011; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; start_it = 1'b1;
    @(negedge clk);
    start_it = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy_it}, 32'd0);
    check("midreset_done", {31'd0, done_it}, 32'd0);
    check("midreset_result_it", result_it, 32'd0);
    check("midreset_result_eo", result_eo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // START held through BUSY with changed operands is ignored
    funct3 = 3'b000; opa = 32'd7; opb = 32'hFFFF_FFFD; start_it = 1'b1;
    @(negedge clk);
    funct3 = 3'b101; opa = 32'd100; opb = 32'd7;
    l = 0; r = 32'hDEAD_BEEF;
    for (int c = 1; c <= 60; c++) begin
      if (done_it) begin
        l = c; r = result_it;
        break;
      end
      @(negedge clk);
    end
    start_it = 1'b0;
    check("held_start_result", r, 32'hFFFF_FFEB);
    check("held_start_lat", l, 32'd34);
    @(negedge clk);
    check("held_start_done_cycle_ignored", {30'd0, busy_it, done_it}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
